// File: rtl/secure_reader_pkg.sv
// Shared state encoding, default parameters and timer sizing for secure_reader.
// No logic of its own; latency and backpressure are defined by the users of this package.
package secure_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AUTH   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEF_DATA_W       = 4;
  localparam int DEF_PW_W         = 4;
  localparam int DEF_MAX_TRIES    = 3;
  localparam int DEF_LOCK_CYCLES  = 8;
  localparam int DEF_AUTH_TIMEOUT = 16;

  // The timer is loaded with (duration - 1), so it only needs to hold max(a, b) - 1.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/secure_reader_lock_timer.sv
// Loadable down-counter whose done flag is high while the count is zero; load wins over decrement.
// Latency: one cycle from load to count; no backpressure, en simply pauses the count.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/secure_reader.sv
// Password-gated read of one of two registers, with retry lockout and an auth timeout.
// Latency: all outputs registered, one cycle after the deciding edge; no backpressure, strobes are single-cycle.
module secure_reader
  import secure_reader_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int PW_W         = DEF_PW_W,
  parameter int MAX_TRIES    = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter int AUTH_TIMEOUT = DEF_AUTH_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PW_W-1:0]   system_password,
  input  logic              request,
  input  logic              select,
  input  logic              confirm,
  input  logic [PW_W-1:0]   input_password,
  input  logic [DATA_W-1:0] qin_left,
  input  logic [DATA_W-1:0] qin_right,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              error,
  output logic              busy,
  output logic              locked
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W  = timer_width(AUTH_TIMEOUT, LOCK_CYCLES);

  state_t            state_q, state_d;
  logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d, error_d;
  logic              tmr_load, tmr_en, tmr_done;
  logic [TMR_W-1:0]  tmr_val;
  logic              accept, pw_match, pw_ok, pw_bad, auth_to, lock_end, hit_max;

  assign pw_match = (input_password == system_password);
  assign accept   = (state_q == ST_IDLE) && request;
  assign pw_ok    = (state_q == ST_AUTH) && confirm && pw_match;
  assign pw_bad   = (state_q == ST_AUTH) && confirm && !pw_match;
  assign auth_to  = (state_q == ST_AUTH) && !confirm && tmr_done;
  assign lock_end = (state_q == ST_LOCKED) && tmr_done;
  assign fail_inc = fail_q + FAIL_W'(1);
  assign hit_max  = (fail_inc == FAIL_W'(MAX_TRIES));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fail_q     <= '0;
      sel_q      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      sel_q      <= sel_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      error      <= error_d;
      busy       <= (state_d != ST_IDLE);
      locked     <= (state_d == ST_LOCKED);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_AUTH;
      end
      ST_AUTH: begin
        if (pw_ok || auth_to)      state_d = ST_IDLE;
        else if (pw_bad && hit_max) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (lock_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer is reloaded with (duration - 1): done is seen on the last cycle of the window.
  always_comb begin
    fail_d   = fail_q;
    sel_d    = sel_q;
    data_d   = data_out;
    valid_d  = pw_ok;
    error_d  = pw_bad || auth_to;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = ((state_q == ST_AUTH) && !confirm) || (state_q == ST_LOCKED);
    if (accept) begin
      sel_d    = select;
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(AUTH_TIMEOUT - 1);
    end
    if (pw_ok) begin
      fail_d = '0;
      data_d = sel_q ? qin_right : qin_left;
    end
    if (pw_bad) begin
      fail_d   = fail_inc;
      tmr_load = 1'b1;
      tmr_val  = hit_max ? TMR_W'(LOCK_CYCLES - 1) : TMR_W'(AUTH_TIMEOUT - 1);
    end
    if (lock_end) fail_d = '0;
  end

  lock_timer #(
    .W(TMR_W)
  ) u_lock_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

endmodule

// File: tb/tb_secure_reader.sv
// Directed bench for secure_reader; observed word is {data_out, data_valid, error, busy, locked}.
module tb_secure_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] system_password = 4'h5;
  logic       request = 1'b0;
  logic       select = 1'b0;
  logic       confirm = 1'b0;
  logic [3:0] input_password = 4'h0;
  logic [3:0] qin_left = 4'h0;
  logic [3:0] qin_right = 4'h0;
  logic [3:0] data_out;
  logic       data_valid, error, busy, locked;
  logic [7:0] obs;

  int n_vec = 0;
  int n_err = 0;

  secure_reader dut (
    .clock           (clock),
    .reset           (reset),
    .system_password (system_password),
    .request         (request),
    .select          (select),
    .confirm         (confirm),
    .input_password  (input_password),
    .qin_left        (qin_left),
    .qin_right       (qin_right),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .error           (error),
    .busy            (busy),
    .locked          (locked)
  );

  always #5 clock = ~clock;

  assign obs = {data_out, data_valid, error, busy, locked};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++; $display("FAIL reset_state: got %h want %h", obs, 8'h00);
    end
    reset = 1'b0;
    tick();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++; $display("FAIL idle_after_reset: got %h want %h", obs, 8'h00);
    end
  endtask

  task automatic test_read_right();
    qin_right = 4'hA; qin_left = 4'h3;
    request = 1'b1; select = 1'b1;
    tick();
    n_vec++;
    if (obs !== 8'hA2 && obs !== 8'h02) begin
      n_err++; $display("FAIL rd_accept: got %h want %h", obs, 8'h02);
    end
    n_vec++;
    if (obs !== 8'h02) begin
      n_err++; $display("FAIL rd_accept_exact: got %h want %h", obs, 8'h02);
    end
    request = 1'b0; select = 1'b0;
    confirm = 1'b1; input_password = 4'h5;
    tick();
    n_vec++;
    if (obs !== 8'hA8) begin
      n_err++; $display("FAIL rd_success: got %h want %h", obs, 8'hA8);
    end
    confirm = 1'b0; qin_right = 4'h7;
    tick();
    n_vec++;
    if (obs !== 8'hA0) begin
      n_err++; $display("FAIL rd_hold: got %h want %h", obs, 8'hA0);
    end
  endtask

  task automatic test_retry();
    qin_left = 4'h6;
    request = 1'b1; select = 1'b0;
    tick();
    request = 1'b0;
    n_vec++;
    if (obs !== 8'hA2) begin
      n_err++; $display("FAIL retry_accept: got %h want %h", obs, 8'hA2);
    end
    for (int i = 0; i < 2; i++) begin
      confirm = 1'b1; input_password = 4'h3;
      tick();
      n_vec++;
      if (obs !== 8'hA6) begin
        n_err++; $display("FAIL retry_wrong%0d: got %h want %h", i, obs, 8'hA6);
      end
      confirm = 1'b0;
      tick();
      n_vec++;
      if (obs !== 8'hA2) begin
        n_err++; $display("FAIL retry_gap%0d: got %h want %h", i, obs, 8'hA2);
      end
    end
    confirm = 1'b1; input_password = 4'h5;
    tick();
    confirm = 1'b0;
    n_vec++;
    if (obs !== 8'h68) begin
      n_err++; $display("FAIL retry_success: got %h want %h", obs, 8'h68);
    end
  endtask

  task automatic test_lockout();
    request = 1'b1; select = 1'b0;
    tick();
    request = 1'b0;
    n_vec++;
    if (obs !== 8'h62) begin
      n_err++; $display("FAIL lock_accept: got %h want %h", obs, 8'h62);
    end
    // Fail count must restart from zero after the previous success.
    confirm = 1'b1; input_password = 4'h3;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (obs !== 8'h66) begin
        n_err++; $display("FAIL lock_wrong%0d: got %h want %h", i, obs, 8'h66);
      end
    end
    tick();
    n_vec++;
    if (obs !== 8'h67) begin
      n_err++; $display("FAIL lock_enter: got %h want %h", obs, 8'h67);
    end
    request = 1'b1; input_password = 4'h5; qin_left = 4'h9;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_vec++;
      if (obs !== 8'h63) begin
        n_err++; $display("FAIL lock_hold%0d: got %h want %h", i, obs, 8'h63);
      end
    end
    tick();
    n_vec++;
    if (obs !== 8'h60) begin
      n_err++; $display("FAIL lock_exit: got %h want %h", obs, 8'h60);
    end
    tick();
    request = 1'b0;
    n_vec++;
    if (obs !== 8'h62) begin
      n_err++; $display("FAIL lock_reaccept: got %h want %h", obs, 8'h62);
    end
    tick();
    confirm = 1'b0;
    n_vec++;
    if (obs !== 8'h98) begin
      n_err++; $display("FAIL lock_read: got %h want %h", obs, 8'h98);
    end
    tick();
    n_vec++;
    if (obs !== 8'h90) begin
      n_err++; $display("FAIL lock_idle: got %h want %h", obs, 8'h90);
    end
  endtask

  task automatic test_timeout();
    qin_left = 4'hF;
    request = 1'b1; select = 1'b0;
    tick();
    request = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_vec++;
      if (obs !== 8'h92) begin
        n_err++; $display("FAIL to_wait%0d: got %h want %h", i, obs, 8'h92);
      end
    end
    tick();
    n_vec++;
    if (obs !== 8'h94) begin
      n_err++; $display("FAIL to_expire: got %h want %h", obs, 8'h94);
    end
    tick();
    n_vec++;
    if (obs !== 8'h90) begin
      n_err++; $display("FAIL to_idle: got %h want %h", obs, 8'h90);
    end
  endtask

  task automatic test_same_cycle_and_reset();
    request = 1'b1; confirm = 1'b1; input_password = 4'h5;
    tick();
    request = 1'b0; confirm = 1'b0;
    n_vec++;
    if (obs !== 8'h92) begin
      n_err++; $display("FAIL same_cycle: got %h want %h", obs, 8'h92);
    end
    tick();
    n_vec++;
    if (obs !== 8'h92) begin
      n_err++; $display("FAIL mid_auth: got %h want %h", obs, 8'h92);
    end
    reset = 1'b1; confirm = 1'b1;
    tick();
    reset = 1'b0; confirm = 1'b0;
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++; $display("FAIL reset_mid_auth: got %h want %h", obs, 8'h00);
    end
    tick();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++; $display("FAIL post_reset_idle: got %h want %h", obs, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_read_right();
    test_retry();
    test_lockout();
    test_timeout();
    test_same_cycle_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/secure_reader.md
SECURE_READER -- requirements
Module: secure_reader

Interface
REQ-001 Parameter DATA_W, default 4, width of stored data words and data_out.
REQ-002 Parameter PW_W, default 4, width of system_password and input_password.
REQ-003 Parameter MAX_TRIES, default 3, consecutive wrong passwords that trigger lockout.
REQ-004 Parameter LOCK_CYCLES, default 8, lockout duration in clock cycles.
REQ-005 Parameter AUTH_TIMEOUT, default 16, cycles allowed in AUTH without confirm.
REQ-006 Port clock, input, 1, single clock; all state changes on rising edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port system_password, input, PW_W, reference password.
REQ-009 Port request, input, 1, read request strobe.
REQ-010 Port select, input, 1, register select: 0 = left, 1 = right; sampled with request.
REQ-011 Port confirm, input, 1, password submit strobe.
REQ-012 Port input_password, input, PW_W, user-supplied password; sampled with confirm.
REQ-013 Port qin_left, input, DATA_W, current left register contents.
REQ-014 Port qin_right, input, DATA_W, current right register contents.
REQ-015 Port data_out, output, DATA_W, last successfully read word.
REQ-016 Port data_valid, output, 1, one-cycle pulse marking new data_out.
REQ-017 Port error, output, 1, one-cycle pulse on wrong password or timeout.
REQ-018 Port busy, output, 1, high whenever state is not IDLE.
REQ-019 Port locked, output, 1, high while state is LOCKED.

Function
REQ-020 FSM states: IDLE, AUTH, LOCKED; all outputs registered.
REQ-021 IDLE with request=1: latch select, clear timeout counter, go AUTH; confirm in the same cycle is ignored.
REQ-022 AUTH with confirm=1 and input_password == system_password: data_out <= qin_left or qin_right per latched select, sampled at that edge; data_valid=1 for the next cycle only; fail count cleared; go IDLE.
REQ-023 AUTH with confirm=1 and mismatch: fail count +1; error=1 for one cycle; if new count == MAX_TRIES go LOCKED, else stay AUTH with timeout counter cleared.
REQ-024 AUTH with no confirm for AUTH_TIMEOUT consecutive cycles: error=1 for one cycle, go IDLE, fail count unchanged.
REQ-025 LOCKED: stay exactly LOCK_CYCLES cycles, then go IDLE with fail count cleared; confirm and request ignored throughout.
REQ-026 request while not IDLE is ignored; select changes after latch have no effect.
REQ-027 data_out holds its value between successful reads; failures and timeouts never modify it.
REQ-028 Fail count persists across IDLE/AUTH transitions; cleared only by success, lockout expiry, or reset.
REQ-029 Changes of qin_left/qin_right outside the success edge are not reflected in data_out.

Reset
REQ-030 reset=1 at a rising edge: state IDLE, data_out=0, data_valid=0, error=0, busy=0, locked=0, fail count=0, timers=0.
REQ-031 Reset has priority over every other input, including mid-AUTH and mid-LOCKED.

Structure
REQ-032 A shared package holds the state encoding (IDLE=0, AUTH=1, LOCKED=2, 2 bits) and the default parameter values.
REQ-033 One sub-module, lock_timer, implements a loadable down-counter with a done flag, used for both the AUTH timeout and the lockout duration.

Verification
REQ-034 reset, qin_right=4'hA, system_password=4'h5; request with select=1; confirm with input_password=4'h5 -> next cycle data_out=4'hA, data_valid=1 for one cycle, busy=0.
REQ-035 Two wrong confirms (4'h3), then correct 4'h5 -> error pulses twice, then data_valid; fail count back to 0.
REQ-036 Three wrong confirms -> third error pulse, locked=1 for exactly 8 cycles; a request during lockout is ignored; a request after lockout is accepted.
REQ-037 request, then no confirm for 16 cycles -> error pulse, state IDLE, data_out unchanged.
REQ-038 request and confirm together in IDLE -> no data_valid; assert reset mid-AUTH -> all outputs 0 next cycle.
